cmul_scheduler: RTL and testbench

Time-shares one `complexmultiplier` among `NUM_REQ` requesters in the FFT/visualizer datapath, such as twiddle-factor and windowing engines. Each cycle, a round-robin arbiter grants at most one pending request. The granted operands enter a fixed-latency pipeline around the combinational multiplier. The product returns to the issuing requester, identified by a one-hot valid and a tag.

---
 rtl/cmul_pkg.sv | 21 ++
 rtl/complexmultiplier.sv | 21 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/cmul_scheduler.sv | 119 +++++++++++
 tb/tb_cmul_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmul_pkg.sv
// Shared complex-number types and widths for the FFT/visualizer multiply path.
package cmul_pkg;

   localparam int CPLX_IN_W  = 32;
   localparam int CPLX_OUT_W = 64;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } cplx16_t;

   typedef struct packed {
      logic signed [31:0] re;
      logic signed [31:0] im;
   } cplx32_t;

   function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/complexmultiplier.sv
// Combinational complex multiply, 16-bit signed in, 32-bit wrapped out.
module complexmultiplier
   import cmul_pkg::*;
(
   input  cplx16_t a_i,
   input  cplx16_t b_i,
   output cplx32_t p_o
);

   logic signed [31:0] rr, ii, ri, ir;

   // Operands widened first so each 16x16 product is exact in 32 bits.
   assign rr = sext16(a_i.re) * sext16(b_i.re);
   assign ii = sext16(a_i.im) * sext16(b_i.im);
   assign ri = sext16(a_i.re) * sext16(b_i.im);
   assign ir = sext16(a_i.im) * sext16(b_i.re);

   assign p_o.re = rr - ii;
   assign p_o.im = ri + ir;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_any_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   sum;
   logic [IDX_W:0]   nxt;
   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      ptr_d     = ptr_q;
      sum       = '0;
      nxt       = '0;
      idx       = '0;
      if (en_i && !rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
               found      = 1'b1;
               gnt_idx_o  = idx;
               gnt_o[idx] = 1'b1;
            end
         end
         if (found) begin
            nxt = {1'b0, gnt_idx_o} + 1'b1;
            if (nxt == (IDX_W+1)'(NUM_REQ)) nxt = '0;
            ptr_d = nxt[IDX_W-1:0];
         end
      end
      gnt_any_o = found;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cmul_scheduler.sv
// Shares one complexmultiplier among NUM_REQ requesters behind a fixed-latency pipe.
// Define CMUL_SCHED_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module cmul_scheduler
   import cmul_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int PIPE_STAGES = 2,
   localparam int TAG_W       = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*CPLX_IN_W-1:0]   req_a,
   input  logic [NUM_REQ*CPLX_IN_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             res_valid,
   output logic [CPLX_OUT_W-1:0]          res_data,
   output logic [TAG_W-1:0]               res_tag,
   output logic                           busy
`ifdef CMUL_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]          grant_cnt
`endif
);

   logic [NUM_REQ-1:0][CPLX_IN_W-1:0] a_arr, b_arr;
   logic [TAG_W-1:0]                  gnt_idx;
   logic                              acc;

   logic [PIPE_STAGES:1]              vld_q;
   logic [PIPE_STAGES:1][TAG_W-1:0]   tag_q;
   cplx16_t                           a1_q, b1_q;
   cplx32_t                           prod;

   assign a_arr = req_a;
   assign b_arr = req_b;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst       (reset),
      .en_i      (en),
      .req_i     (req_valid),
      .gnt_o     (req_ready),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (acc)
   );

   // Data/tag registers load only behind a valid bit, so the last stage
   // naturally holds its previous result while res_valid is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         tag_q <= '0;
         a1_q  <= '0;
         b1_q  <= '0;
      end else begin
         vld_q[1] <= acc;
         if (acc) begin
            tag_q[1] <= gnt_idx;
            a1_q     <= a_arr[gnt_idx];
            b1_q     <= b_arr[gnt_idx];
         end
         for (int k = 2; k <= PIPE_STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) tag_q[k] <= tag_q[k-1];
         end
      end
   end

   complexmultiplier u_mul (
      .a_i (a1_q),
      .b_i (b1_q),
      .p_o (prod)
   );

   generate
      if (PIPE_STAGES == 1) begin : g_p1
         assign res_data = prod;
      end else begin : g_pn
         logic [PIPE_STAGES:2][CPLX_OUT_W-1:0] prod_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               prod_q <= '0;
            end else begin
               if (vld_q[1]) prod_q[2] <= prod;
               for (int k = 3; k <= PIPE_STAGES; k++)
                  if (vld_q[k-1]) prod_q[k] <= prod_q[k-1];
            end
         end
         assign res_data = prod_q[PIPE_STAGES];
      end
   endgenerate

   assign res_tag = tag_q[PIPE_STAGES];
   assign busy    = |vld_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_res
      assign res_valid[i] = vld_q[PIPE_STAGES] && (tag_q[PIPE_STAGES] == TAG_W'(i));
   end

`ifdef CMUL_SCHED_STATS_EN
   logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i] && req_valid[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cmul_scheduler.sv
// Self-checking bench for cmul_scheduler: vector tables, directed corners, random vs queue model.
module tb_cmul_scheduler;

   localparam int N = 4;
   localparam int P = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_a, req_b;
   logic [N-1:0]    req_ready, res_valid;
   logic [63:0]     res_data;
   logic [1:0]      res_tag;
   logic            busy;
`ifdef CMUL_SCHED_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   int checks = 0;
   int errors = 0;

   cmul_scheduler #(.NUM_REQ(N), .PIPE_STAGES(P)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .busy      (busy)
`ifdef CMUL_SCHED_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model: in-flight entries with their age in cycles since accept.
   typedef struct {
      int          tag;
      logic [63:0] data;
      int          age;
   } ent_t;

   ent_t        q[$];
   int          ptr;
   int          last_w;
   logic [63:0] last_data;
   int          last_tag;
   int          res_seen;
   int          mcnt[N];
   logic [31:0] oa[N], ob[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input longint re, input longint im);
      logic [63:0] r;
      r[63:32] = re[31:0];
      r[31:0]  = im[31:0];
      return r;
   endfunction

   function automatic logic [63:0] cref(input logic [31:0] a, input logic [31:0] b);
      longint ar, ai, br, bi;
      ar = longint'($signed(a[31:16]));
      ai = longint'($signed(a[15:0]));
      br = longint'($signed(b[31:16]));
      bi = longint'($signed(b[15:0]));
      return pk(ar*br - ai*bi, ar*bi + ai*br);
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_a[i*32 +: 32] = oa[i];
         req_b[i*32 +: 32] = ob[i];
      end
   endtask

   // One clock: check the grant before the edge, advance the model, check outputs after.
   task automatic step();
      int w, idx;
      logic [N-1:0] er, ev;
      ent_t e;
      #2;
      w = -1;
      if (en && !reset)
         for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
         end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      @(posedge clk);
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age > P) void'(q.pop_front());
      if (w >= 0) begin
         e.tag  = w;
         e.data = cref(req_a[w*32 +: 32], req_b[w*32 +: 32]);
         e.age  = 1;
         q.push_back(e);
         ptr = (w + 1) % N;
         if (mcnt[w] < 65535) mcnt[w]++;
      end
      last_w = w;
      #1;
      ev = '0;
      if (q.size() > 0 && q[0].age == P) begin
         ev[q[0].tag] = 1'b1;
         last_data    = q[0].data;
         last_tag     = q[0].tag;
      end
      if (res_valid != '0) res_seen++;
      check("res_valid", 64'(res_valid), 64'(ev));
      check("res_data",  res_data, last_data);
      check("res_tag",   64'(res_tag), 64'(last_tag));
      check("busy",      64'(busy), 64'(q.size() > 0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst res_valid", 64'(res_valid), 64'd0);
      check("rst res_data",  res_data, 64'd0);
      check("rst res_tag",   64'(res_tag), 64'd0);
      check("rst busy",      64'(busy), 64'd0);
      check("rst req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      ptr       = 0;
      last_w    = -1;
      last_data = '0;
      last_tag  = 0;
      foreach (mcnt[i]) mcnt[i] = 0;
   endtask

   typedef struct {
      logic [N-1:0] vld;
      logic         en;
      logic [N-1:0] exp_rdy;
   } rvec_t;

   typedef struct {
      logic [31:0] a, b;
      logic [63:0] exp;
   } pvec_t;

   rvec_t rtab[12];
   pvec_t ptab[6];

   initial begin
      // Grant sequence starting from pointer 0 after reset.
      rtab[0]  = '{4'b1111, 1'b1, 4'b0001};
      rtab[1]  = '{4'b1111, 1'b1, 4'b0010};
      rtab[2]  = '{4'b1111, 1'b1, 4'b0100};
      rtab[3]  = '{4'b1111, 1'b1, 4'b1000};
      rtab[4]  = '{4'b1111, 1'b1, 4'b0001};
      rtab[5]  = '{4'b0001, 1'b1, 4'b0001};
      rtab[6]  = '{4'b1010, 1'b0, 4'b0000};
      rtab[7]  = '{4'b1010, 1'b1, 4'b0010};
      rtab[8]  = '{4'b1001, 1'b1, 4'b1000};
      rtab[9]  = '{4'b0000, 1'b1, 4'b0000};
      rtab[10] = '{4'b0110, 1'b1, 4'b0010};
      rtab[11] = '{4'b0011, 1'b1, 4'b0001};

      ptab[0] = '{32'h0064_0000, 32'h7641_CF05, pk(3027300, -1253900)};
      ptab[1] = '{32'h8000_8000, 32'h8000_8000, 64'h0000_0000_8000_0000};
      ptab[2] = '{32'h0001_0002, 32'h0003_0004, pk(-5, 10)};
      ptab[3] = '{32'h7FFF_0000, 32'h7FFF_0000, pk(1073676289, 0)};
      ptab[4] = '{32'h0000_0001, 32'h0000_0001, pk(-1, 0)};
      ptab[5] = '{32'hFFFF_FFFF, 32'h0001_FFFF, pk(-2, 0)};

      reset = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      res_seen = 0;
      foreach (oa[i]) begin oa[i] = 32'(i * 3 + 1); ob[i] = 32'(i * 5 + 2); end
      do_reset();

      // Arbitration table.
      drive();
      foreach (rtab[t]) begin
         req_valid = rtab[t].vld;
         en        = rtab[t].en;
         #2;
         check($sformatf("tbl_ready[%0d]", t), 64'(req_ready), 64'(rtab[t].exp_rdy));
         step();
      end
      req_valid = '0;
      repeat (P + 1) step();

      // Product table through a single requester at a time.
      foreach (ptab[t]) begin
         oa[t % N] = ptab[t].a;
         ob[t % N] = ptab[t].b;
         drive();
         req_valid = '0;
         req_valid[t % N] = 1'b1;
         step();
         req_valid = '0;
         repeat (P - 1) step();
         check($sformatf("tbl_data[%0d]", t),  res_data, ptab[t].exp);
         check($sformatf("tbl_tag[%0d]", t),   64'(res_tag), 64'(t % N));
         check($sformatf("tbl_valid[%0d]", t), 64'(res_valid), 64'(1 << (t % N)));
         step();
      end

      // All requesting from a fresh pointer: strict rotation.
      do_reset();
      foreach (oa[i]) begin oa[i] = 32'h1000_0100 * 32'(i + 1); ob[i] = 32'h0203_F00D + 32'(i); end
      drive();
      en = 1'b1;
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         #2;
         check("rotate", 64'(req_ready), 64'(1 << (c % N)));
         step();
      end
      req_valid = '0;
      repeat (P + 1) step();

      // Enable low with requests pending: in-flight entries still drain.
      res_seen  = 0;
      req_valid = 4'b0011;
      repeat (2) step();
      en = 1'b0;
      req_valid = '1;
      repeat (4) step();
      check("en_off results", 64'(res_seen), 64'd2);
      check("en_off busy", 64'(busy), 64'd0);
      req_valid = '0;
      en = 1'b1;
      step();

      // Reset mid-flight: nothing in flight may surface afterwards.
      req_valid = '1;
      repeat (2) step();
      do_reset();
      req_valid = '0;
      res_seen  = 0;
      repeat (4) step();
      check("rst_flight results", 64'(res_seen), 64'd0);
      req_valid = '1;
      #2;
      check("rst ptr restart", 64'(req_ready), 64'd1);
      step();
      req_valid = '0;
      repeat (P + 1) step();

      // Random traffic honoring the hold-until-accepted rule, with occasional drops.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && last_w != i) begin
               if ($urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
            end else begin
               req_valid[i] = ($urandom_range(0, 1) == 1);
               oa[i] = $urandom();
               ob[i] = ($urandom_range(0, 15) == 0) ? 32'h8000_8000 : $urandom();
            end
         end
         en = ($urandom_range(0, 9) != 0);
         drive();
         step();
      end
      req_valid = '0;
      repeat (P + 1) step();

`ifdef CMUL_SCHED_STATS_EN
      do_reset();
      en = 1'b1;
      req_valid = 4'b0001; repeat (3) step();
      req_valid = 4'b0100; repeat (5) step();
      req_valid = 4'b0010; repeat (70000) step();
      req_valid = '0;
      step();
      check("cnt sat", 64'(grant_cnt[31:16]), 64'hFFFF);
      for (int i = 0; i < N; i++)
         check($sformatf("cnt[%0d]", i), 64'(grant_cnt[i*16 +: 16]), 64'(mcnt[i]));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
